// File: rtl/operand_loader.sv
// Input conditioning for the ALU/display pair: synchronizes switches and the load button,
// debounces the button, and captures the operands on each clean press with a one-cycle Load.
module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] SwA,
  input  logic [2:0] SwB,
  input  logic [1:0] SwOp,
  input  logic       BtnLoad,
  output logic [2:0] PortA,
  output logic [2:0] PortB,
  output logic [1:0] Opcode,
  output logic       Load,
  output logic       Pressed
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    HELD   = 2'd2,
    DISARM = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0]      r_btn_sync;
  logic [SYNC_STAGES-1:0][2:0] r_a_sync;
  logic [SYNC_STAGES-1:0][2:0] r_b_sync;
  logic [SYNC_STAGES-1:0][1:0] r_op_sync;

  logic       w_btn_s;
  logic [2:0] w_a_s;
  logic [2:0] w_b_s;
  logic [1:0] w_op_s;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_port_a;
  logic [2:0]    r_port_b;
  logic [1:0]    r_opcode;
  logic          r_load;
  logic          r_pressed;

  // Multi-stage synchronizer on every raw input; index 0 is the first stage.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_btn_sync <= '0;
      r_a_sync   <= '0;
      r_b_sync   <= '0;
      r_op_sync  <= '0;
    end else begin
      r_btn_sync <= {r_btn_sync[SYNC_STAGES-2:0], BtnLoad};
      r_a_sync   <= {r_a_sync[SYNC_STAGES-2:0], SwA};
      r_b_sync   <= {r_b_sync[SYNC_STAGES-2:0], SwB};
      r_op_sync  <= {r_op_sync[SYNC_STAGES-2:0], SwOp};
    end
  end

  assign w_btn_s = r_btn_sync[SYNC_STAGES-1];
  assign w_a_s   = r_a_sync[SYNC_STAGES-1];
  assign w_b_s   = r_b_sync[SYNC_STAGES-1];
  assign w_op_s  = r_op_sync[SYNC_STAGES-1];

  // Debounce FSM; cnt is the run length of btn_s disagreeing with Pressed.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_cnt     <= CNT_ZERO;
      r_port_a  <= 3'd0;
      r_port_b  <= 3'd0;
      r_opcode  <= 2'd0;
      r_load    <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_btn_s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              r_state   <= HELD;
              r_cnt     <= CNT_ZERO;
              r_port_a  <= w_a_s;
              r_port_b  <= w_b_s;
              r_opcode  <= w_op_s;
              r_load    <= 1'b1;
              r_pressed <= 1'b1;
            end else begin
              r_state <= ARM;
              r_cnt   <= CNT_ONE;
            end
          end else begin
            r_cnt <= CNT_ZERO;
          end
        end
        ARM: begin
          if (!w_btn_s) begin
            r_state <= IDLE;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= HELD;
            r_cnt     <= CNT_ZERO;
            r_port_a  <= w_a_s;
            r_port_b  <= w_b_s;
            r_opcode  <= w_op_s;
            r_load    <= 1'b1;
            r_pressed <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!w_btn_s) begin
            // A single-cycle debounce releases immediately, mirroring the press side.
            if (DEBOUNCE_CYCLES == 1) begin
              r_state   <= IDLE;
              r_cnt     <= CNT_ZERO;
              r_pressed <= 1'b0;
            end else begin
              r_state <= DISARM;
              r_cnt   <= CNT_ONE;
            end
          end else begin
            r_cnt <= CNT_ZERO;
          end
        end
        DISARM: begin
          if (w_btn_s) begin
            r_state <= HELD;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= IDLE;
            r_cnt     <= CNT_ZERO;
            r_pressed <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_cnt     <= CNT_ZERO;
          r_pressed <= 1'b0;
        end
      endcase
    end
  end

  assign PortA   = r_port_a;
  assign PortB   = r_port_b;
  assign Opcode  = r_opcode;
  assign Load    = r_load;
  assign Pressed = r_pressed;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, using a
// run-length debounce model over a delay line of raw samples.
module tb_operand_loader;

  localparam int DB = 4;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sw_a;
  logic [2:0] sw_b;
  logic [1:0] sw_op;
  logic       btn;
  logic [2:0] port_a;
  logic [2:0] port_b;
  logic [1:0] opcode;
  logic       load;
  logic       pressed;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic       q_btn [SS];
  logic [2:0] q_a   [SS];
  logic [2:0] q_b   [SS];
  logic [1:0] q_op  [SS];
  logic       m_pressed;
  int         m_run;
  logic       m_load;
  logic [2:0] m_a;
  logic [2:0] m_b;
  logic [1:0] m_op;

  operand_loader #(.DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SS)) dut (
    .Clock(clk), .Reset(rst), .SwA(sw_a), .SwB(sw_b), .SwOp(sw_op), .BtnLoad(btn),
    .PortA(port_a), .PortB(port_b), .Opcode(opcode), .Load(load), .Pressed(pressed)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    logic bs;
    if (rst) begin
      for (int i = 0; i < SS; i++) begin
        q_btn[i] = 1'b0; q_a[i] = 3'd0; q_b[i] = 3'd0; q_op[i] = 2'd0;
      end
      m_pressed = 1'b0; m_run = 0; m_load = 1'b0;
      m_a = 3'd0; m_b = 3'd0; m_op = 2'd0;
    end else begin
      bs = q_btn[SS-1];
      m_load = 1'b0;
      if (bs != m_pressed) begin
        m_run = m_run + 1;
        if (m_run == DB) begin
          m_pressed = bs;
          m_run = 0;
          if (bs) begin
            m_a = q_a[SS-1]; m_b = q_b[SS-1]; m_op = q_op[SS-1];
            m_load = 1'b1;
          end
        end
      end else begin
        m_run = 0;
      end
      for (int i = SS - 1; i > 0; i--) begin
        q_btn[i] = q_btn[i-1]; q_a[i] = q_a[i-1]; q_b[i] = q_b[i-1]; q_op[i] = q_op[i-1];
      end
      q_btn[0] = btn; q_a[0] = sw_a; q_b[0] = sw_b; q_op[0] = sw_op;
    end
  endtask

  // Advance one clock edge, update the model, and leave time for outputs to settle.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sw_a = 3'($urandom); sw_b = 3'($urandom); sw_op = 2'($urandom);
      tick();
      n_tests++;
      if ({port_a, port_b, opcode, load, pressed} !== 10'd0) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got a=%0d b=%0d op=%0d ld=%0b pr=%0b want all 0",
                 i, port_a, port_b, opcode, load, pressed);
      end
    end
    rst = 1'b0; btn = 1'b0;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_clean_press();
    sw_a = 3'd5; sw_b = 3'd3; sw_op = 2'd2; btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++;
      if (load !== (i == 5) || pressed !== (i >= 5)) begin
        n_fail++;
        $display("FAIL clean_press edge=k+%0d got ld=%0b pr=%0b want ld=%0b pr=%0b",
                 i, load, pressed, (i == 5), (i >= 5));
      end
    end
    n_tests++;
    if (port_a !== 3'd5 || port_b !== 3'd3 || opcode !== 2'd2) begin
      n_fail++;
      $display("FAIL clean_capture got a=%0d b=%0d op=%0d want a=5 b=3 op=2", port_a, port_b, opcode);
    end
  endtask

  task automatic test_release_glitch();
    int loads = 0;
    btn = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) btn = 1'b1;
      tick();
      loads += int'(load);
      n_tests++;
      if (pressed !== 1'b1) begin
        n_fail++;
        $display("FAIL release_glitch cyc=%0d got pr=%0b want pr=1", i, pressed);
      end
    end
    n_tests++;
    if (loads != 0) begin
      n_fail++;
      $display("FAIL release_glitch_load got loads=%0d want 0", loads);
    end
  endtask

  task automatic test_switch_while_held();
    int loads = 0;
    sw_a = 3'd7;
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (port_a !== 3'd5) begin
      n_fail++;
      $display("FAIL held_switch got a=%0d want a=5", port_a);
    end
    btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      loads += int'(load);
    end
    n_tests++;
    if (pressed !== 1'b0 || loads != 0 || port_a !== 3'd5) begin
      n_fail++;
      $display("FAIL release got pr=%0b loads=%0d a=%0d want pr=0 loads=0 a=5", pressed, loads, port_a);
    end
    btn = 1'b1;
    loads = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      loads += int'(load);
    end
    n_tests++;
    if (loads != 1 || port_a !== 3'd7 || port_b !== 3'd3 || opcode !== 2'd2) begin
      n_fail++;
      $display("FAIL repress got loads=%0d a=%0d b=%0d op=%0d want loads=1 a=7 b=3 op=2",
               loads, port_a, port_b, opcode);
    end
    btn = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_bounce();
    int loads = 0;
    int pos   = -1;
    sw_a = 3'd1; sw_b = 3'd6; sw_op = 2'd1;
    for (int i = 0; i < 14; i++) begin
      btn = (i == 3) ? 1'b0 : 1'b1;
      tick();
      if (load) begin
        loads++;
        pos = i;
      end
    end
    n_tests++;
    if (loads != 1 || pos != 9) begin
      n_fail++;
      $display("FAIL bounce got loads=%0d at=%0d want loads=1 at=9", loads, pos);
    end
    n_tests++;
    if (port_a !== 3'd1 || port_b !== 3'd6 || opcode !== 2'd1) begin
      n_fail++;
      $display("FAIL bounce_capture got a=%0d b=%0d op=%0d want a=1 b=6 op=1", port_a, port_b, opcode);
    end
    btn = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_reset_mid_count();
    int loads = 0;
    btn = 1'b1; sw_a = 3'd2; sw_b = 3'd4; sw_op = 2'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      loads += int'(load);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if (loads != 0 || {port_a, port_b, opcode, load, pressed} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_mid got loads=%0d a=%0d b=%0d op=%0d ld=%0b pr=%0b want all 0",
               loads, port_a, port_b, opcode, load, pressed);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++;
      if (load !== (i == 5)) begin
        n_fail++;
        $display("FAIL reset_mid_load edge=%0d got ld=%0b want %0b", i, load, (i == 5));
      end
    end
    n_tests++;
    if (port_a !== 3'd2 || port_b !== 3'd4 || opcode !== 2'd3) begin
      n_fail++;
      $display("FAIL reset_mid_capture got a=%0d b=%0d op=%0d want a=2 b=4 op=3", port_a, port_b, opcode);
    end
    btn = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_random();
    int   run_left = 0;
    logic prev_load = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (run_left == 0) begin
        btn = 1'($urandom);
        run_left = int'($urandom_range(1, 8));
      end
      run_left--;
      rst = ($urandom_range(0, 79) == 0);
      sw_a = 3'($urandom); sw_b = 3'($urandom); sw_op = 2'($urandom);
      tick();
      n_tests++;
      if (port_a !== m_a || port_b !== m_b || opcode !== m_op || load !== m_load || pressed !== m_pressed) begin
        n_fail++;
        $display("FAIL random cyc=%0d got a=%0d b=%0d op=%0d ld=%0b pr=%0b want a=%0d b=%0d op=%0d ld=%0b pr=%0b",
                 i, port_a, port_b, opcode, load, pressed, m_a, m_b, m_op, m_load, m_pressed);
      end
      if (prev_load && load) begin
        n_fail++;
        $display("FAIL load_twice cyc=%0d got two consecutive Load cycles want one", i);
      end
      prev_load = load;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0; sw_a = 3'd0; sw_b = 3'd0; sw_op = 2'd0;
    test_reset();
    test_clean_press();
    test_release_glitch();
    test_switch_while_held();
    test_bounce();
    test_reset_mid_count();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
